cache_miss_mshr: RTL
====================

Name: cache_miss_mshr

Overview:
- Per-thread miss status holding registers (MSHR) between the cache tag/lookup stage and main memory.
- Accepts one outstanding miss per hardware thread, together with the victim way already chosen by the set LRU.
- Arbitrates miss fetches to memory round-robin and returns responses as line fills.
- The fill strobe, set, way and thread drive the LRU second-thread update port (update_req_mt/update_set_mt/update_way_mt/update_thread_mt) and the data/tag arrays.

Parameters:
- NUM_THREADS, 4, hardware threads per core (one MSHR entry each); THR_W = $clog2(NUM_THREADS).
- NUM_SET, 4, cache sets; NUM_SET_W = $clog2(NUM_SET).
- WAYS_PER_SET, 4, ways per set; WAYS_PER_SET_W = $clog2(WAYS_PER_SET).
- LADDR_W, 28, line address width (byte address minus line offset); low NUM_SET_W bits are the set, the rest are the tag.
- LINE_W, 128, cache line width in bits.

Ports:
- clock  in  1  core clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- miss_req  in  1  new miss from lookup stage.
- miss_thread  in  THR_W  thread that missed.
- miss_laddr  in  LADDR_W  missing line address.
- miss_way  in  WAYS_PER_SET_W  victim way returned by the LRU for this miss.
- miss_ready  out  NUM_THREADS  bit t = entry t is IDLE and can accept a miss.
- mem_req_valid  out  1  memory fetch request valid.
- mem_req_laddr  out  LADDR_W  fetch line address.
- mem_req_thread  out  THR_W  tag returned with the response.
- mem_req_ready  in  1  memory accepts the request.
- mem_rsp_valid  in  1  memory response valid (one per cycle, any order across threads).
- mem_rsp_thread  in  THR_W  thread of the response.
- mem_rsp_data  in  LINE_W  line data.
- fill_valid  out  1  one-cycle fill strobe; also the LRU update_req_mt.
- fill_set  out  NUM_SET_W  set to fill.
- fill_way  out  WAYS_PER_SET_W  way to fill.
- fill_tag  out  LADDR_W-NUM_SET_W  tag to write.
- fill_thread  out  THR_W  thread whose miss completes.
- fill_data  out  LINE_W  line data.
- rsp_err  out  1  sticky: a response arrived for an entry not in WAIT_RSP.

Behaviour:
- Reset:
  - All entries IDLE; miss_ready = all ones.
  - mem_req_valid = 0, fill_valid = 0, rsp_err = 0.
  - All data outputs 0; round-robin pointer = 0.
- Entry FSM, per thread: IDLE -> WAIT_ISSUE -> WAIT_RSP -> IDLE.
  - miss_req with miss_ready[miss_thread] = 1: captures laddr and way at the clock edge and moves to WAIT_ISSUE.
  - miss_req to a non-IDLE entry is a protocol violation: ignored, state unchanged.
- Issue:
  - mem_req_valid is registered; it is high while a selected entry is in WAIT_ISSUE.
  - Selection is round-robin starting from the entry after the last granted one.
  - laddr and thread are held stable until mem_req_ready = 1.
  - On the handshake edge, the entry moves to WAIT_RSP and the next request may be presented the following cycle.
  - Minimum latency is 1 cycle: accept at edge E, mem_req_valid high after E.
- Response:
  - mem_rsp_valid with the entry in WAIT_RSP: at the next edge, fill_valid = 1 for exactly one cycle with the captured set/way/tag, and the entry returns to IDLE.
  - miss_ready[t] is therefore high in the same cycle as the fill strobe, so a new miss for t can be accepted then.
- Unexpected response (entry not in WAIT_RSP): dropped, no fill, rsp_err set until reset.
- Simultaneous events:
  - A response and a new miss for different threads in one cycle are both processed.
  - A miss arriving for thread t while its response is arriving: rejected, because miss_ready[t] = 0 that cycle.
- Asserting reset mid-operation discards all entries and any in-flight fill. A memory response after reset release is flagged as rsp_err.

Optional Feature:
- Macro: MSHR_MERGE_EN.
- Enabled:
  - A miss whose laddr equals that of an entry in WAIT_ISSUE or WAIT_RSP enters MERGED and issues no memory request.
  - When the primary response arrives, each MERGED entry of that line latches the data into a per-entry LINE_W buffer and moves to FILL_PEND.
  - Fill priority: a memory-response fill first, then FILL_PEND entries by lowest thread id, one per cycle, each with its own way. The entry goes IDLE when its fill issues.
  - A merge is only made to entries that have not yet received data.
- Disabled: every miss issues its own memory request, with no data buffers and no MERGED/FILL_PEND states.

Test Plan:
- Single miss: t0, laddr 0x0000123, way 2, mem_req_ready = 1, response 3 cycles later with data 0xA5..A5 -> one fill_valid pulse with set 3, way 2, tag 0x000048, thread 0; miss_ready[0] high again in the fill cycle.
- Round-robin: t0..t3 miss on consecutive cycles, mem_req_ready held low 5 cycles then high -> grants in order 0, 1, 2, 3, one per cycle.
- Out-of-order: responses return for threads 2, 0, 3, 1 -> four fills in that order, each carrying its own captured set/way.
- Unexpected response for idle thread 1 -> no fill_valid, rsp_err = 1 and sticky.
- Reset asserted while t0 is in WAIT_RSP, then its response arrives -> no fill, rsp_err = 1, miss_ready = 4'b1111.
- With MSHR_MERGE_EN: t0 and t1 miss the same laddr 0x10, ways 0 and 1 -> exactly one mem_req; fills to way 0 (thread 0) then way 1 (thread 1) on consecutive cycles with identical data.

Source files
------------

// File: rtl/cache_miss_mshr.sv
// cache_miss_mshr: per-thread miss status holding registers between the cache lookup stage and
// main memory. Each hardware thread owns one entry that holds its miss line address and the
// victim way. Pending fetches are issued round-robin, and memory responses come back as
// one-cycle line fills.
//
// Optional feature: define MSHR_MERGE_EN to merge a miss into an outstanding fetch of the same
// line. The merged entry waits for the primary data and then fills from its own line buffer.
//
// Ports:
//   clock, reset                          core clock, asynchronous active-low reset
//   miss_req/thread/laddr/way             new miss from lookup, with the LRU victim way
//   miss_ready[NUM_THREADS]               entry t is idle and can accept a miss
//   mem_req_valid/laddr/thread, ready     registered fetch request to memory
//   mem_rsp_valid/thread/data             memory response (any order across threads)
//   fill_valid/set/way/tag/thread/data    one-cycle fill strobe; also drives the LRU update port
//   rsp_err                               sticky: response arrived for an entry not waiting for one
module cache_miss_mshr #(
    parameter int unsigned NUM_THREADS    = 4,
    parameter int unsigned NUM_SET        = 4,
    parameter int unsigned WAYS_PER_SET   = 4,
    parameter int unsigned LADDR_W        = 28,
    parameter int unsigned LINE_W         = 128,
    parameter int unsigned THR_W          = $clog2(NUM_THREADS),
    parameter int unsigned NUM_SET_W      = $clog2(NUM_SET),
    parameter int unsigned WAYS_PER_SET_W = $clog2(WAYS_PER_SET)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         miss_req,
    input  logic [THR_W-1:0]             miss_thread,
    input  logic [LADDR_W-1:0]           miss_laddr,
    input  logic [WAYS_PER_SET_W-1:0]    miss_way,
    output logic [NUM_THREADS-1:0]       miss_ready,
    output logic                         mem_req_valid,
    output logic [LADDR_W-1:0]           mem_req_laddr,
    output logic [THR_W-1:0]             mem_req_thread,
    input  logic                         mem_req_ready,
    input  logic                         mem_rsp_valid,
    input  logic [THR_W-1:0]             mem_rsp_thread,
    input  logic [LINE_W-1:0]            mem_rsp_data,
    output logic                         fill_valid,
    output logic [NUM_SET_W-1:0]         fill_set,
    output logic [WAYS_PER_SET_W-1:0]    fill_way,
    output logic [LADDR_W-NUM_SET_W-1:0] fill_tag,
    output logic [THR_W-1:0]             fill_thread,
    output logic [LINE_W-1:0]            fill_data,
    output logic                         rsp_err
);

    localparam int NT = int'(NUM_THREADS);

`ifdef MSHR_MERGE_EN
    typedef enum logic [2:0] {StIdle, StWaitIssue, StWaitRsp, StMerged, StFillPend} state_e;
`else
    typedef enum logic [1:0] {StIdle, StWaitIssue, StWaitRsp} state_e;
`endif

    state_e                      state_q [NUM_THREADS];
    state_e                      state_d [NUM_THREADS];
    logic [LADDR_W-1:0]          laddr_q [NUM_THREADS];
    logic [WAYS_PER_SET_W-1:0]   way_q   [NUM_THREADS];

    logic                        req_valid_q, req_valid_d;
    logic [THR_W-1:0]            req_thread_q, req_thread_d;
    logic [LADDR_W-1:0]          req_laddr_q, req_laddr_d;
    logic [THR_W-1:0]            rr_q, rr_d;

    logic                        fill_valid_q, fill_valid_d;
    logic [THR_W-1:0]            fill_thread_q, fill_thread_d;
    logic [LADDR_W-1:0]          fill_laddr_q, fill_laddr_d;
    logic [WAYS_PER_SET_W-1:0]   fill_way_q, fill_way_d;
    logic [LINE_W-1:0]           fill_data_q, fill_data_d;
    logic                        rsp_err_q, rsp_err_d;

    logic                        miss_acc, rsp_hit, handshake, merge_hit;
    logic [NUM_THREADS-1:0]      cand;
    logic                        sel_found;
    logic [THR_W-1:0]            sel_thread, rr_idx;

`ifdef MSHR_MERGE_EN
    logic [LINE_W-1:0]           buf_q [NUM_THREADS];
    logic [NUM_THREADS-1:0]      buf_we;
    logic                        pend_found;
    logic [THR_W-1:0]            pend_thread;
`endif

    // Event decode and issue candidates.
    always_comb begin
        miss_acc  = miss_req && (state_q[miss_thread] == StIdle);
        rsp_hit   = mem_rsp_valid && (state_q[mem_rsp_thread] == StWaitRsp);
        handshake = req_valid_q && mem_req_ready;
        merge_hit = 1'b0;
`ifdef MSHR_MERGE_EN
        // An entry whose data lands this cycle no longer counts as outstanding.
        for (int t = 0; t < NT; t++) begin
            if ((laddr_q[t] == miss_laddr) &&
                ((state_q[t] == StWaitIssue) ||
                 ((state_q[t] == StWaitRsp) && !(rsp_hit && (mem_rsp_thread == THR_W'(t)))))) begin
                merge_hit = 1'b1;
            end
        end
`endif
        for (int t = 0; t < NT; t++) begin
            miss_ready[t] = (state_q[t] == StIdle);
            cand[t] = (state_q[t] == StWaitIssue) &&
                      !(handshake && (req_thread_q == THR_W'(t)));
        end
        // A freshly accepted miss is eligible immediately: one-cycle issue latency.
        if (miss_acc && !merge_hit) begin
            cand[miss_thread] = 1'b1;
        end
    end

    // Round-robin pick starting after the last granted entry; nearest candidate wins.
    always_comb begin
        sel_found  = 1'b0;
        sel_thread = '0;
        rr_idx     = '0;
        for (int i = NT; i >= 1; i--) begin
            rr_idx = THR_W'((int'(rr_q) + i) % NT);
            if (cand[rr_idx]) begin
                sel_found  = 1'b1;
                sel_thread = rr_idx;
            end
        end

        req_valid_d  = req_valid_q;
        req_thread_d = req_thread_q;
        req_laddr_d  = req_laddr_q;
        rr_d         = rr_q;
        // The presented request is held until it is accepted.
        if (!req_valid_q || handshake) begin
            req_valid_d = sel_found;
            if (sel_found) begin
                req_thread_d = sel_thread;
                rr_d         = sel_thread;
                req_laddr_d  = (miss_acc && (miss_thread == sel_thread)) ? miss_laddr
                                                                         : laddr_q[sel_thread];
            end
        end
    end

    // Entry transitions and fill generation.
    always_comb begin
        for (int t = 0; t < NT; t++) begin
            state_d[t] = state_q[t];
        end
        fill_valid_d  = 1'b0;
        fill_thread_d = fill_thread_q;
        fill_laddr_d  = fill_laddr_q;
        fill_way_d    = fill_way_q;
        fill_data_d   = fill_data_q;
        rsp_err_d     = rsp_err_q | (mem_rsp_valid & ~rsp_hit);

        if (handshake) begin
            state_d[req_thread_q] = StWaitRsp;
        end
        if (rsp_hit) begin
            state_d[mem_rsp_thread] = StIdle;
            fill_valid_d  = 1'b1;
            fill_thread_d = mem_rsp_thread;
            fill_laddr_d  = laddr_q[mem_rsp_thread];
            fill_way_d    = way_q[mem_rsp_thread];
            fill_data_d   = mem_rsp_data;
        end

`ifdef MSHR_MERGE_EN
        buf_we      = '0;
        pend_found  = 1'b0;
        pend_thread = '0;
        for (int t = NT - 1; t >= 0; t--) begin
            if (state_q[t] == StFillPend) begin
                pend_found  = 1'b1;
                pend_thread = THR_W'(t);
            end
        end
        if (rsp_hit) begin
            for (int t = 0; t < NT; t++) begin
                if ((state_q[t] == StMerged) && (laddr_q[t] == laddr_q[mem_rsp_thread])) begin
                    state_d[t] = StFillPend;
                    buf_we[t]  = 1'b1;
                end
            end
        end else if (pend_found) begin
            // Buffered fills only use cycles the memory response path leaves free.
            state_d[pend_thread] = StIdle;
            fill_valid_d  = 1'b1;
            fill_thread_d = pend_thread;
            fill_laddr_d  = laddr_q[pend_thread];
            fill_way_d    = way_q[pend_thread];
            fill_data_d   = buf_q[pend_thread];
        end
        if (miss_acc) begin
            state_d[miss_thread] = merge_hit ? StMerged : StWaitIssue;
        end
`else
        if (miss_acc) begin
            state_d[miss_thread] = StWaitIssue;
        end
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int t = 0; t < NT; t++) begin
                state_q[t] <= StIdle;
                laddr_q[t] <= '0;
                way_q[t]   <= '0;
            end
            req_valid_q   <= 1'b0;
            req_thread_q  <= '0;
            req_laddr_q   <= '0;
            rr_q          <= '0;
            fill_valid_q  <= 1'b0;
            fill_thread_q <= '0;
            fill_laddr_q  <= '0;
            fill_way_q    <= '0;
            fill_data_q   <= '0;
            rsp_err_q     <= 1'b0;
        end else begin
            for (int t = 0; t < NT; t++) begin
                state_q[t] <= state_d[t];
            end
            if (miss_acc) begin
                laddr_q[miss_thread] <= miss_laddr;
                way_q[miss_thread]   <= miss_way;
            end
            req_valid_q   <= req_valid_d;
            req_thread_q  <= req_thread_d;
            req_laddr_q   <= req_laddr_d;
            rr_q          <= rr_d;
            fill_valid_q  <= fill_valid_d;
            fill_thread_q <= fill_thread_d;
            fill_laddr_q  <= fill_laddr_d;
            fill_way_q    <= fill_way_d;
            fill_data_q   <= fill_data_d;
            rsp_err_q     <= rsp_err_d;
        end
    end

`ifdef MSHR_MERGE_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int t = 0; t < NT; t++) begin
                buf_q[t] <= '0;
            end
        end else begin
            for (int t = 0; t < NT; t++) begin
                if (buf_we[t]) begin
                    buf_q[t] <= mem_rsp_data;
                end
            end
        end
    end
`endif

    assign mem_req_valid  = req_valid_q;
    assign mem_req_laddr  = req_laddr_q;
    assign mem_req_thread = req_thread_q;
    assign fill_valid     = fill_valid_q;
    assign fill_set       = fill_laddr_q[NUM_SET_W-1:0];
    assign fill_tag       = fill_laddr_q[LADDR_W-1:NUM_SET_W];
    assign fill_way       = fill_way_q;
    assign fill_thread    = fill_thread_q;
    assign fill_data      = fill_data_q;
    assign rsp_err        = rsp_err_q;

endmodule
